// File: rtl/rheed_pkg.sv
// Shared constants and types for the RHEED CNN result path.
package rheed_pkg;

    localparam int unsigned N_CNN_OUT = 5;
    localparam int unsigned CNN_OUT_W = 8;

    // Bit offsets of the fields inside the packed result record
    localparam int unsigned SEQ_LSB  = 64;
    localparam int unsigned MASK_LSB = 96;
    localparam int unsigned TO_BIT   = 112;

    typedef enum logic {
        COLLECT,
        EMIT
    } rpk_state_t;

endpackage

// File: rtl/cnn_result_packer_if.sv
// CNN channel streams plus the host-facing record stream of the packer.
// slave: the packer's view; master: the surrounding fabric's view.
interface cnn_result_packer_if #(
    parameter int unsigned N_OUT  = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 256
);

    logic [N_OUT-1:0]        s_axis_tvalid;
    logic [N_OUT-1:0]        s_axis_tready;
    logic [N_OUT*DATA_W-1:0] s_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [OUT_W-1:0]        m_axis_tdata;
    logic                    m_axis_tlast;

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        output s_axis_tready,
        output m_axis_tvalid,
        output m_axis_tdata,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid,
        output s_axis_tdata,
        input  s_axis_tready,
        input  m_axis_tvalid,
        input  m_axis_tdata,
        input  m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/rpk_channel_slot.sv
// One CNN channel: captures a single byte per record and flags it as received.
module rpk_channel_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              tvalid_i,
    input  logic [DATA_W-1:0] tdata_i,
    output logic              tready_o,
    output logic              acc_o,
    output logic              got_o,
    output logic [DATA_W-1:0] data_o
);

    logic              got_q, got_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Ready only while collecting and nothing captured yet; clear wipes the byte
    // so a forced record reports missing channels as zero.
    always_comb begin
        tready_o = en_i & ~got_q;
        acc_o    = tvalid_i & tready_o;
        got_d    = got_q;
        data_d   = data_q;
        if (clr_i) begin
            got_d  = 1'b0;
            data_d = '0;
        end else if (acc_o) begin
            got_d  = 1'b1;
            data_d = tdata_i;
        end
    end

    // Capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            got_q  <= 1'b0;
            data_q <= '0;
        end else begin
            got_q  <= got_d;
            data_q <= data_d;
        end
    end

    assign got_o  = got_q;
    assign data_o = data_q;

endmodule

// File: rtl/cnn_result_packer.sv
// Gathers one byte from each CNN output channel and emits a single-beat
// result record with sequence number, valid mask and timeout flag.
module cnn_result_packer
    import rheed_pkg::*;
#(
    parameter int unsigned N_OUT       = N_CNN_OUT,
    parameter int unsigned DATA_W      = CNN_OUT_W,
    parameter int unsigned OUT_W       = 256,
    parameter int unsigned SEQ_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1048575
) (
    input  logic                  clk,
    input  logic                  reset,
    cnn_result_packer_if.slave    axis,
    output logic [SEQ_W-1:0]      frame_count,
    output logic [SEQ_W-1:0]      timeout_count,
    output logic                  busy
);

    rpk_state_t state_q, state_d;

    logic                          run_q;
    logic                          collect_en;
    logic                          out_hs;
    logic                          all_full;
    logic                          timeout_hit;
    logic [N_OUT-1:0]              ready;
    logic [N_OUT-1:0]              acc;
    logic [N_OUT-1:0]              got;
    logic [N_OUT-1:0][DATA_W-1:0]  slot_data;
    logic [SEQ_W-1:0]              timer_q, timer_d;
    logic                          to_q, to_d;
    logic [SEQ_W-1:0]              frame_count_q, frame_count_d;
    logic [SEQ_W-1:0]              timeout_count_q, timeout_count_d;
    logic [OUT_W-1:0]              rec;

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        rpk_channel_slot #(.DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .en_i     (collect_en),
            .clr_i    (out_hs),
            .tvalid_i (axis.s_axis_tvalid[g]),
            .tdata_i  (axis.s_axis_tdata[g*DATA_W +: DATA_W]),
            .tready_o (ready[g]),
            .acc_o    (acc[g]),
            .got_o    (got[g]),
            .data_o   (slot_data[g])
        );
    end

    assign axis.s_axis_tready = ready;
    assign axis.m_axis_tlast  = 1'b1;

    assign out_hs   = (state_q == EMIT) & axis.m_axis_tready;
    assign all_full = &(got | acc);
    // Fires on the cycle whose closing edge brings the timer to TIMEOUT_CYC
    assign timeout_hit = (TIMEOUT_CYC != 0) && (got != '0)
                         && (timer_q == SEQ_W'(TIMEOUT_CYC - 1));

    // Startup flop: holds all channel readies low for the first cycle after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run_q <= 1'b0;
        else       run_q <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    // FSM next state; completion and timeout both leave COLLECT
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (all_full || timeout_hit) state_d = EMIT;
            EMIT:    if (axis.m_axis_tready)      state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs
    always_comb begin
        collect_en         = run_q & (state_q == COLLECT);
        axis.m_axis_tvalid = (state_q == EMIT);
        busy               = (got != '0) | (state_q == EMIT);
    end

    // Timer, timeout flag and counters; a full frame beats a coincident timeout
    always_comb begin
        timer_d         = timer_q;
        to_d            = to_q;
        frame_count_d   = frame_count_q;
        timeout_count_d = timeout_count_q;
        if (state_q == COLLECT) begin
            if ((got == '0) && (acc != '0)) timer_d = '0;
            else if (got != '0)             timer_d = timer_q + SEQ_W'(1);
            if (!all_full && timeout_hit)   to_d = 1'b1;
        end
        if (out_hs) begin
            to_d            = 1'b0;
            frame_count_d   = frame_count_q + SEQ_W'(1);
            timeout_count_d = timeout_count_q + SEQ_W'(to_q);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q         <= '0;
            to_q            <= 1'b0;
            frame_count_q   <= '0;
            timeout_count_q <= '0;
        end else begin
            timer_q         <= timer_d;
            to_q            <= to_d;
            frame_count_q   <= frame_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // Record assembly; all inputs are frozen while EMIT, so the beat stays stable
    always_comb begin
        rec                      = '0;
        rec[N_OUT*DATA_W-1:0]    = slot_data;
        rec[SEQ_LSB +: SEQ_W]    = frame_count_q;
        rec[MASK_LSB +: N_OUT]   = got;
        rec[TO_BIT]              = to_q;
    end

    assign axis.m_axis_tdata = rec;
    assign frame_count       = frame_count_q;
    assign timeout_count     = timeout_count_q;

endmodule

// File: tb/tb_cnn_result_packer.sv
// Directed bench for cnn_result_packer with a queue-based record scoreboard.
module tb_cnn_result_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnn_result_packer_if #(.N_OUT(5), .DATA_W(8), .OUT_W(256)) ifa ();
    cnn_result_packer_if #(.N_OUT(5), .DATA_W(8), .OUT_W(256)) ifb ();

    logic [31:0] fc_a, tc_a, fc_b, tc_b;
    logic        busy_a, busy_b;

    cnn_result_packer #(
        .N_OUT(5), .DATA_W(8), .OUT_W(256), .SEQ_W(32), .TIMEOUT_CYC(1048575)
    ) dut_a (
        .clk(clk), .reset(reset), .axis(ifa),
        .frame_count(fc_a), .timeout_count(tc_a), .busy(busy_a)
    );

    cnn_result_packer #(
        .N_OUT(5), .DATA_W(8), .OUT_W(256), .SEQ_W(32), .TIMEOUT_CYC(16)
    ) dut_b (
        .clk(clk), .reset(reset), .axis(ifb),
        .frame_count(fc_b), .timeout_count(tc_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] q_a [$];
    logic [255:0] q_b [$];
    logic [255:0] exp_hold;
    logic [4:0]   acc;
    int           start [5] = '{0, 3, 7, 8, 20};
    logic         second;
    logic         bad_stall, bad_valid, bad_data, bad_ready, bad_busy;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_rec(input logic [39:0] bytes, input logic [31:0] seq,
                                            input logic [4:0] mask, input logic flag);
        logic [255:0] r;
        r          = '0;
        r[39:0]    = bytes;
        r[95:64]   = seq;
        r[100:96]  = mask;
        r[112]     = flag;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare each record at the cycle it is handed off
    always @(negedge clk) begin
        if (ifa.m_axis_tvalid && ifa.m_axis_tready) begin
            if (q_a.size() == 0) chk("a_unexpected_rec", ifa.m_axis_tdata, '0);
            else begin
                chk("a_rec", ifa.m_axis_tdata, q_a.pop_front());
                chk("a_tlast", ifa.m_axis_tlast, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.m_axis_tvalid && ifb.m_axis_tready) begin
            if (q_b.size() == 0) chk("b_unexpected_rec", ifb.m_axis_tdata, '0);
            else begin
                chk("b_rec", ifb.m_axis_tdata, q_b.pop_front());
                chk("b_tlast", ifb.m_axis_tlast, 1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        ifa.s_axis_tvalid = '0; ifa.s_axis_tdata = '0; ifa.m_axis_tready = 1'b1;
        ifb.s_axis_tvalid = '0; ifb.s_axis_tdata = '0; ifb.m_axis_tready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // T1: all channels together right after reset
        chk("t1_rst_tready", ifa.s_axis_tready, 0);
        chk("t1_rst_tvalid", ifa.m_axis_tvalid, 0);
        chk("t1_rst_fc", fc_a, 0);
        chk("t1_rst_busy", busy_a, 0);
        ifa.s_axis_tvalid = 5'h1F;
        ifa.s_axis_tdata  = 40'h1413121110;
        q_a.push_back(mk_rec(40'h1413121110, 0, 5'h1F, 1'b0));
        tick();
        chk("t1_tready_run", ifa.s_axis_tready, 5'h1F);
        chk("t1_no_early_valid", ifa.m_axis_tvalid, 0);
        tick();
        ifa.s_axis_tvalid = '0;
        chk("t1_latency", ifa.m_axis_tvalid, 1);
        chk("t1_tready_emit", ifa.s_axis_tready, 0);
        chk("t1_busy_emit", busy_a, 1);
        tick();
        chk("t1_fc", fc_a, 1);
        chk("t1_valid_drop", ifa.m_axis_tvalid, 0);
        chk("t1_busy_idle", busy_a, 0);

        // T2: staggered channels, channel 2 sends two beats back-to-back
        q_a.push_back(mk_rec(40'h2423222120, 1, 5'h1F, 1'b0));
        q_a.push_back(mk_rec(40'h4443324140, 2, 5'h1F, 1'b0));
        second = 1'b0;
        bad_stall = 1'b0;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 5; i++)
                if (c == start[i]) begin
                    ifa.s_axis_tvalid[i] = 1'b1;
                    ifa.s_axis_tdata[8*i +: 8] = 8'(32'h20 + i);
                end
            if (c >= 8 && c <= 21 && ifa.s_axis_tready[2] !== 1'b0) bad_stall = 1'b1;
            if (c == 22) chk("t2_ch2_resume", ifa.s_axis_tready[2], 1);
            acc = ifa.s_axis_tvalid & ifa.s_axis_tready;
            tick();
            for (int i = 0; i < 5; i++)
                if (acc[i]) begin
                    if (i == 2 && !second) begin
                        second = 1'b1;
                        ifa.s_axis_tdata[23:16] = 8'h32;
                    end else begin
                        ifa.s_axis_tvalid[i] = 1'b0;
                    end
                end
        end
        chk("t2_ch2_stall", bad_stall, 0);
        chk("t2_fc", fc_a, 2);
        ifa.s_axis_tvalid = 5'b11011;
        ifa.s_axis_tdata[7:0]   = 8'h40;
        ifa.s_axis_tdata[15:8]  = 8'h41;
        ifa.s_axis_tdata[31:24] = 8'h43;
        ifa.s_axis_tdata[39:32] = 8'h44;
        tick();
        ifa.s_axis_tvalid = '0;
        tick();
        tick();
        chk("t2_fc2", fc_a, 3);

        // T3: host backpressure for 50 cycles
        ifa.m_axis_tready = 1'b0;
        ifa.s_axis_tvalid = 5'h1F;
        ifa.s_axis_tdata  = 40'h5453525150;
        exp_hold = mk_rec(40'h5453525150, 3, 5'h1F, 1'b0);
        q_a.push_back(exp_hold);
        tick();
        ifa.s_axis_tvalid = '0;
        bad_valid = 1'b0; bad_data = 1'b0; bad_ready = 1'b0; bad_busy = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (ifa.m_axis_tvalid !== 1'b1)       bad_valid = 1'b1;
            if (ifa.m_axis_tdata !== exp_hold)    bad_data  = 1'b1;
            if (ifa.s_axis_tready !== 5'h00)      bad_ready = 1'b1;
            if (busy_a !== 1'b1)                  bad_busy  = 1'b1;
            tick();
        end
        chk("t3_valid_held", bad_valid, 0);
        chk("t3_data_stable", bad_data, 0);
        chk("t3_tready_low", bad_ready, 0);
        chk("t3_busy", bad_busy, 0);
        chk("t3_fc_hold", fc_a, 3);
        ifa.m_axis_tready = 1'b1;
        tick();
        chk("t3_fc_inc", fc_a, 4);
        chk("t3_valid_drop", ifa.m_axis_tvalid, 0);
        chk("t3_single", q_a.size(), 0);

        // T4: timeout with channels 2 and 4 silent (TIMEOUT_CYC=16)
        ifb.s_axis_tvalid = 5'b01011;
        ifb.s_axis_tdata  = 40'h0063006160;
        q_b.push_back(mk_rec(40'h0063006160, 0, 5'h0B, 1'b1));
        tick();
        ifb.s_axis_tvalid = '0;
        repeat (15) tick();
        chk("t4_not_early", ifb.m_axis_tvalid, 0);
        chk("t4_busy", busy_b, 1);
        tick();
        chk("t4_forced", ifb.m_axis_tvalid, 1);
        tick();
        chk("t4_tc", tc_b, 1);
        chk("t4_fc", fc_b, 1);

        // T4 corner: last channel lands on the timeout cycle
        ifb.s_axis_tvalid = 5'b01111;
        ifb.s_axis_tdata  = 40'h0073727170;
        q_b.push_back(mk_rec(40'h7473727170, 1, 5'h1F, 1'b0));
        tick();
        ifb.s_axis_tvalid = '0;
        repeat (15) tick();
        ifb.s_axis_tvalid[4] = 1'b1;
        ifb.s_axis_tdata[39:32] = 8'h74;
        tick();
        ifb.s_axis_tvalid = '0;
        chk("t4c_emit", ifb.m_axis_tvalid, 1);
        tick();
        chk("t4c_tc", tc_b, 1);
        chk("t4c_fc", fc_b, 2);

        // T5: asynchronous reset while a record is pending
        ifa.m_axis_tready = 1'b0;
        ifa.s_axis_tvalid = 5'h1F;
        ifa.s_axis_tdata  = 40'h8483828180;
        tick();
        ifa.s_axis_tvalid = '0;
        tick();
        chk("t5_pending", ifa.m_axis_tvalid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_valid_drop", ifa.m_axis_tvalid, 0);
        chk("t5_fc_clr", fc_a, 0);
        chk("t5_busy_clr", busy_a, 0);
        tick();
        reset = 1'b0;
        chk("t5_tready_run", ifa.s_axis_tready, 0);
        ifa.m_axis_tready = 1'b1;
        ifa.s_axis_tvalid = 5'h1F;
        ifa.s_axis_tdata  = 40'h9493929190;
        q_a.push_back(mk_rec(40'h9493929190, 0, 5'h1F, 1'b0));
        tick();
        tick();
        ifa.s_axis_tvalid = '0;
        tick();
        tick();
        chk("t5_fc", fc_a, 1);

        repeat (3) tick();
        chk("a_drain", q_a.size(), 0);
        chk("b_drain", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
